// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory store path.
//   MEM_AW / MEM_DW : default address / data widths
//   store_entry_t   : one buffered store {addr, data}
//   state_t         : store-unit FSM states {IDLE, REQ}
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
  } store_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/store_fifo.sv
// -----------------------------------------------------------------------------
// store_fifo
// Synchronous FIFO holding pending stores. Full/empty come from a registered
// occupancy count, never from pointer equality, so both pointers simply wrap
// modulo DEPTH (DEPTH must be a power of two).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : write i_wdata at the write pointer (ignored when full)
//   i_wdata    : entry to write
//   i_pop      : advance the read pointer (ignored when empty)
//   o_rdata    : entry at the read pointer (combinational read of the head)
//   o_count    : number of entries held
//   o_full     : o_count == DEPTH
//   o_empty    : o_count == 0
// -----------------------------------------------------------------------------
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Guard here too so a misbehaving caller cannot corrupt the count.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/memory_store_unit.sv
// -----------------------------------------------------------------------------
// memory_store_unit
// Buffers datapath stores in a small FIFO and issues them to memory one at a
// time over a req/ack write handshake, so slow writes do not stall the
// datapath.
//
// Handshakes:
//   Store side : a store is taken at a rising edge where st_valid && st_ready.
//                st_ready is !full from the registered count only, so an ack
//                in the same cycle never re-opens it. A refused store must be
//                held by the datapath.
//   Memory side: mem_wr_req/mem_addr/mem_wdata are registered and held
//                unchanged until an edge with mem_wr_ack=1. On that edge the
//                next entry (if any) is loaded with req kept high, otherwise
//                req drops. mem_wr_ack is ignored while req is low.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   st_valid/st_addr/st_data: store request from the datapath
//   st_ready                : buffer can accept a store
//   mem_wr_req/mem_addr/mem_wdata/mem_wr_ack : memory write port
//   count                   : stores buffered, excluding the one in flight
//   drained                 : nothing buffered and no write in flight
//   dbg_state               : current FSM state
// -----------------------------------------------------------------------------
module memory_store_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  output logic          mem_wr_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_wr_ack,
  output logic [CW-1:0] count,
  output logic          drained,
  output state_t        dbg_state
);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_wr_req;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [AW+DW-1:0]  w_head;

  assign w_push = st_valid && !w_full;

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({st_addr, st_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Pops only look at the registered count, so a store accepted on the same
  // edge as the final ack is picked up one cycle later rather than bypassed.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        if (mem_wr_ack) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_req <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_wr_req <= (w_next_state == REQ);
      // Address/data only change on a pop; after the last ack they keep
      // their final values.
      if (w_pop) begin
        r_addr  <= w_head[AW+DW-1:DW];
        r_wdata <= w_head[DW-1:0];
      end
    end
  end

  assign st_ready   = !w_full;
  assign mem_wr_req = r_wr_req;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign count      = w_count;
  assign drained    = w_empty && (r_state == IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_memory_store_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_store_unit
// Drives memory_store_unit cycle by cycle and compares every output against a
// queue-based reference model of the store buffer plus one in-flight write.
// A scoreboard of accepted stores checks that completed writes reach memory in
// acceptance order.
// -----------------------------------------------------------------------------
module tb_memory_store_unit;
  import mem_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr_ack;
  logic [CW-1:0] count;
  logic          drained;
  state_t        dbg_state;

  always #5 clk = ~clk;

  memory_store_unit #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr_ack (mem_wr_ack),
    .count      (count),
    .drained    (drained),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  store_entry_t  m_buf[$];          // stores waiting, oldest first
  bit            m_busy;            // a write is outstanding on the memory port
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [31:0]   exp_q[$];          // accepted stores not yet acknowledged
  int            n_acc;
  logic [AW-1:0] seen_addr;         // DUT outputs sampled last cycle
  logic [DW-1:0] seen_data;

  // One clock cycle: apply inputs, advance the model at the edge, then check.
  task automatic drive_cycle(input bit r, input bit v, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit ack);
    bit           acc;
    int           pre;
    store_entry_t e;
    logic [31:0]  exp_w;
    rst        = r;
    st_valid   = v;
    st_addr    = a;
    st_data    = d;
    mem_wr_ack = ack;
    @(posedge clk);
    if (r) begin
      m_buf.delete();
      exp_q.delete();
      m_busy = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      pre = m_buf.size();
      acc = v && (pre < DEPTH);
      if (m_busy && ack) begin
        // a write completes: it must be the oldest outstanding accepted store
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("sb_order", {seen_addr, seen_data}, exp_w);
        end
      end
      if (pre > 0 && (!m_busy || ack)) begin
        e      = m_buf.pop_front();
        m_addr = e.addr;
        m_data = e.data;
        m_busy = 1'b1;
      end else if (m_busy && ack) begin
        m_busy = 1'b0;
      end
      if (acc) begin
        e.addr = a;
        e.data = d;
        m_buf.push_back(e);
        exp_q.push_back({a, d});
        n_acc++;
      end
    end
    #1;
    check_eq("st_ready",   st_ready,   m_buf.size() < DEPTH);
    check_eq("count",      count,      m_buf.size());
    check_eq("mem_wr_req", mem_wr_req, m_busy);
    check_eq("mem_addr",   mem_addr,   m_addr);
    check_eq("mem_wdata",  mem_wdata,  m_data);
    check_eq("drained",    drained,    (m_buf.size() == 0) && !m_busy);
    check_eq("dbg_state",  dbg_state == REQ, m_busy);
    seen_addr = mem_addr;
    seen_data = mem_wdata;
  endtask

  task automatic idle_cycle(input bit ack);
    drive_cycle(1'b0, 1'b0, '0, '0, ack);
  endtask

  task automatic push_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ack);
    drive_cycle(1'b0, 1'b1, a, d, ack);
  endtask

  // Ack continuously until the model says everything is written.
  task automatic drain_all();
    int guard;
    guard = 0;
    while ((m_busy || m_buf.size() != 0) && guard < 200) begin
      idle_cycle(1'b1);
      guard++;
    end
    check_eq("drain_timeout", guard < 200, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int target;
    int cyc;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; mem_wr_ack = 1'b0;
    m_busy = 1'b0; m_addr = '0; m_data = '0; n_acc = 0;
    seen_addr = '0; seen_data = '0;

    // reset state
    drive_cycle(1'b1, 1'b0, '0, '0, 1'b0);
    drive_cycle(1'b1, 1'b1, 16'hffff, 16'hffff, 1'b1);
    check_eq("rst_drained",  drained,    1'b1);
    check_eq("rst_st_ready", st_ready,   1'b1);
    check_eq("rst_req",      mem_wr_req, 1'b0);

    // 1: single store, ack three cycles after req
    push_cycle(16'h0010, 16'd54, 1'b0);
    check_eq("t1_req_not_yet", mem_wr_req, 1'b0);
    idle_cycle(1'b0);
    check_eq("t1_req_rise", mem_wr_req, 1'b1);
    check_eq("t1_addr",     mem_addr,   16'h0010);
    check_eq("t1_data",     mem_wdata,  16'd54);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    check_eq("t1_req_fall", mem_wr_req, 1'b0);
    check_eq("t1_drained",  drained,    1'b1);
    check_eq("t1_addr_kept", mem_addr,  16'h0010);

    // 2: fill to full with ack held low
    push_cycle(16'h0100, 16'd977,  1'b0);
    push_cycle(16'h0101, 16'd0,    1'b0);
    push_cycle(16'h0102, 16'd6516, 1'b0);
    push_cycle(16'h0103, 16'd515,  1'b0);
    push_cycle(16'h0104, 16'd333,  1'b0);
    check_eq("t2_count_full", count,    4);
    check_eq("t2_not_ready",  st_ready, 1'b0);
    check_eq("t2_inflight",   mem_wdata, 16'd977);
    push_cycle(16'h0104, 16'd333, 1'b0);   // still refused
    check_eq("t2_refused", count, 4);

    // 3: back-to-back drain, 333 held on the bus until it is taken
    push_cycle(16'h0104, 16'd333, 1'b1);
    check_eq("t3_b2b_req", mem_wr_req, 1'b1);
    check_eq("t3_next",    mem_wdata,  16'd0);
    push_cycle(16'h0104, 16'd333, 1'b1);   // taken here, while popping 6516
    drain_all();
    check_eq("t3_last",    mem_wdata, 16'd333);
    check_eq("t3_drained", drained,   1'b1);

    // 4: simultaneous push and pop with count=2 in REQ
    push_cycle(16'h0200, 16'd11, 1'b0);
    push_cycle(16'h0201, 16'd12, 1'b0);
    push_cycle(16'h0202, 16'd13, 1'b0);
    check_eq("t4_count_pre", count,      2);
    check_eq("t4_req_pre",   mem_wr_req, 1'b1);
    push_cycle(16'h0203, 16'd1804, 1'b1);
    check_eq("t4_count_post", count,     2);
    check_eq("t4_next",       mem_wdata, 16'd12);
    drain_all();

    // 5: stream 3*DEPTH stores with random ack gaps and repeated addresses
    target = n_acc + 3 * DEPTH;
    cyc = 0;
    while (n_acc < target && cyc < 2000) begin
      drive_cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)),
                  16'($urandom_range(0, 16'hffff)), $urandom_range(0, 2) == 0);
      cyc++;
    end
    check_eq("t5_stream_done", n_acc >= target, 1'b1);
    cyc = 0;
    while ((m_busy || m_buf.size() != 0) && cyc < 500) begin
      idle_cycle($urandom_range(0, 2) == 0);
      cyc++;
    end
    check_eq("t5_drained", drained, 1'b1);
    check_eq("t5_sb_empty", exp_q.size(), 0);

    // 6: reset while in REQ with count=3; later acks must not matter
    push_cycle(16'h0300, 16'd21, 1'b0);
    push_cycle(16'h0301, 16'd22, 1'b0);
    push_cycle(16'h0302, 16'd23, 1'b0);
    push_cycle(16'h0303, 16'd24, 1'b0);
    check_eq("t6_count_pre", count, 3);
    drive_cycle(1'b1, 1'b1, 16'h0304, 16'd25, 1'b1);
    check_eq("t6_req",      mem_wr_req, 1'b0);
    check_eq("t6_count",    count,      0);
    check_eq("t6_drained",  drained,    1'b1);
    check_eq("t6_st_ready", st_ready,   1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    check_eq("t6_ack_ignored", mem_wr_req, 1'b0);
    push_cycle(16'h0400, 16'd99, 1'b1);
    idle_cycle(1'b0);
    check_eq("t6_recover", mem_wdata, 16'd99);
    drain_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
